// File: rtl/gpio_pkg.sv
// ---------------------------------------------------------------------------
// gpio_pkg
// Shared definitions for the GPIO interrupt bank: register indices within the
// 8-word window, the maximum channel count, and byte-lane write helpers.
// ---------------------------------------------------------------------------
package gpio_pkg;

  localparam int MAX_WIDTH = 32;

  localparam logic [2:0] REG_DATA_IN  = 3'd0;
  localparam logic [2:0] REG_DATA_OUT = 3'd1;
  localparam logic [2:0] REG_IRQ_EN   = 3'd2;
  localparam logic [2:0] REG_RISE_EN  = 3'd3;
  localparam logic [2:0] REG_FALL_EN  = 3'd4;
  localparam logic [2:0] REG_PENDING  = 3'd5;
  localparam logic [2:0] REG_DB_DIV   = 3'd6;

  // Expands the 4 byte enables into a 32-bit bit mask.
  function automatic logic [31:0] laneMask(input logic [3:0] we);
    return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  endfunction

  // Replaces only the enabled byte lanes of an existing register value.
  function automatic logic [31:0] byteMerge(input logic [31:0] oldVal,
                                            input logic [31:0] data,
                                            input logic [3:0]  we);
    return (oldVal & ~laneMask(we)) | (data & laneMask(we));
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// ---------------------------------------------------------------------------
// gpio_debounce
// One input channel: synchroniser chain, tick-driven debounce counter,
// debounced level and single-cycle rise/fall strobes.
// Ports:
//   clk_100M  in   clock
//   rst       in   synchronous active-high reset
//   i_tick    in   debounce sample strobe from the shared prescaler
//   i_in      in   raw asynchronous pin
//   o_q       out  debounced level
//   o_rise    out  one-cycle pulse when o_q goes 0->1
//   o_fall    out  one-cycle pulse when o_q goes 1->0
// ---------------------------------------------------------------------------
module gpio_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLES     = 4
) (
  input  logic clk_100M,
  input  logic rst,
  input  logic i_tick,
  input  logic i_in,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [3:0]             r_count;
  logic                   r_q;
  logic                   r_qDly;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  // A new level is accepted only after SAMPLES consecutive ticks in which the
  // synchronised input disagrees with the current level; any agreeing tick
  // restarts the count, so short glitches never reach o_q.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      r_sync  <= '0;
      r_count <= '0;
      r_q     <= 1'b0;
      r_qDly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
      r_qDly <= r_q;
      if (i_tick) begin
        if (w_s == r_q) begin
          r_count <= '0;
        end else if (r_count == 4'(SAMPLES - 1)) begin
          r_q     <= w_s;
          r_count <= '0;
        end else begin
          r_count <= r_count + 4'd1;
        end
      end
    end
  end

  assign o_q    = r_q;
  assign o_rise = r_q & ~r_qDly;
  assign o_fall = ~r_q & r_qDly;

endmodule

// File: rtl/gpio_irq_bank.sv
// ---------------------------------------------------------------------------
// gpio_irq_bank
// GPIO bank on the 8-bit-address peripheral bus: debounced inputs, output
// latch, per-channel rise/fall interrupt pending bits (write-1-to-clear) and
// a single registered interrupt line.
// Ports:
//   clk_100M   in   clock
//   rst        in   synchronous active-high reset
//   i_pin_in   in   raw asynchronous inputs [WIDTH]
//   o_pin_out  out  DATA_OUT[WIDTH-1:0]
//   i_addr     in   byte address; window hit on addr[7:5]==BASE[5:3], index addr[4:2]
//   i_din      in   write data
//   i_we       in   byte write enables
//   i_en       in   bus strobe, qualifies writes
//   o_dout     out  registered read data (1-cycle latency, 0 on miss)
//   o_irq      out  registered OR of enabled pending bits
// ---------------------------------------------------------------------------
module gpio_irq_bank
  import gpio_pkg::*;
#(
  parameter int         WIDTH       = 16,
  parameter logic [5:0] BASE        = 6'h10,
  parameter int         SYNC_STAGES = 2,
  parameter int         SAMPLES     = 4,
  parameter int         DB_BITS     = 16
) (
  input  logic              clk_100M,
  input  logic              rst,
  input  logic [WIDTH-1:0]  i_pin_in,
  output logic [WIDTH-1:0]  o_pin_out,
  input  logic [7:0]        i_addr,
  input  logic [31:0]       i_din,
  input  logic [3:0]        i_we,
  input  logic              i_en,
  output logic [31:0]       o_dout,
  output logic              o_irq
);

  // Channel registers are kept 32 bits wide; bits at or above WIDTH are
  // forced to zero on every write so they read back as 0.
  localparam logic [31:0] CH_MASK = (WIDTH >= MAX_WIDTH) ? 32'hFFFF_FFFF
                                                         : ((32'd1 << WIDTH) - 32'd1);

  logic [31:0]        r_dataOut;
  logic [31:0]        r_irqEn;
  logic [31:0]        r_riseEn;
  logic [31:0]        r_fallEn;
  logic [31:0]        r_pending;
  logic [DB_BITS-1:0] r_dbDiv;
  logic [DB_BITS-1:0] r_presc;
  logic [31:0]        r_dout;
  logic               r_irq;

  logic               w_hit;
  logic [2:0]         w_idx;
  logic               w_wr;
  logic               w_tick;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_rise;
  logic [WIDTH-1:0]   w_fall;
  logic [31:0]        w_set;
  logic [31:0]        w_clr;
  logic [31:0]        w_dbMerge;
  logic [DB_BITS-1:0] w_dbDivNext;
  logic               w_unused;

  assign w_hit       = (i_addr[7:5] == BASE[5:3]);
  assign w_idx       = i_addr[4:2];
  assign w_wr        = i_en & w_hit;
  assign w_tick      = (r_presc == '0);
  assign w_dbMerge   = byteMerge(32'(r_dbDiv), i_din, i_we);
  assign w_dbDivNext = w_dbMerge[DB_BITS-1:0];
  assign w_set       = 32'((w_rise & r_riseEn[WIDTH-1:0]) | (w_fall & r_fallEn[WIDTH-1:0]));
  assign w_clr       = (w_wr && (w_idx == REG_PENDING)) ? (i_din & laneMask(i_we)) : 32'h0;
  assign w_unused    = ^{i_addr[1:0], w_dbMerge};

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    gpio_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .SAMPLES     (SAMPLES)
    ) u_db (
      .clk_100M (clk_100M),
      .rst      (rst),
      .i_tick   (w_tick),
      .i_in     (i_pin_in[gi]),
      .o_q      (w_q[gi]),
      .o_rise   (w_rise[gi]),
      .o_fall   (w_fall[gi])
    );
  end

  // A DB_DIV write restarts the prescaler from the new value so a new rate
  // takes effect without waiting out a long old period.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_wr && (w_idx == REG_DB_DIV)) begin
      r_presc <= w_dbDivNext;
    end else if (w_tick) begin
      r_presc <= r_dbDiv;
    end else begin
      r_presc <= r_presc - DB_BITS'(1);
    end
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      r_dataOut <= '0;
      r_irqEn   <= '0;
      r_riseEn  <= '0;
      r_fallEn  <= '0;
      r_dbDiv   <= '0;
    end else if (w_wr) begin
      case (w_idx)
        REG_DATA_OUT: r_dataOut <= byteMerge(r_dataOut, i_din, i_we) & CH_MASK;
        REG_IRQ_EN:   r_irqEn   <= byteMerge(r_irqEn,   i_din, i_we) & CH_MASK;
        REG_RISE_EN:  r_riseEn  <= byteMerge(r_riseEn,  i_din, i_we) & CH_MASK;
        REG_FALL_EN:  r_fallEn  <= byteMerge(r_fallEn,  i_din, i_we) & CH_MASK;
        REG_DB_DIV:   r_dbDiv   <= w_dbDivNext;
        default: ;
      endcase
    end
  end

  // Clearing happens before setting, so an edge arriving in the same cycle
  // as a write-1-to-clear leaves the bit set.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      r_pending <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_irq     <= |(r_pending & r_irqEn);
    end
  end

  always_ff @(posedge clk_100M) begin
    if (rst || !w_hit) begin
      r_dout <= '0;
    end else begin
      case (w_idx)
        REG_DATA_IN:  r_dout <= 32'(w_q);
        REG_DATA_OUT: r_dout <= r_dataOut;
        REG_IRQ_EN:   r_dout <= r_irqEn;
        REG_RISE_EN:  r_dout <= r_riseEn;
        REG_FALL_EN:  r_dout <= r_fallEn;
        REG_PENDING:  r_dout <= r_pending;
        REG_DB_DIV:   r_dout <= 32'(r_dbDiv);
        default:      r_dout <= '0;
      endcase
    end
  end

  assign o_pin_out = r_dataOut[WIDTH-1:0];
  assign o_dout    = r_dout;
  assign o_irq     = r_irq;

endmodule
